// File: rtl/l2_write_buffer.sv
// l2_write_buffer: eviction write buffer between the L2 pmem port and
// physical memory. Dirty-line writebacks are absorbed into a small circular
// FIFO and acknowledged quickly. Buffered lines drain to pmem whenever the
// upstream port is idle. Writes to a line that is already buffered coalesce
// in place, so at most one entry ever matches a given address.
//
// Optional feature, selected by the macro WB_FORWARD_EN:
//   defined   - a read that hits the buffer is answered from the buffer.
//   undefined - a read that hits the buffer forces drains until no entry
//               matches, then reads the freshly written line from pmem.
//
// Handshake: upstream mem_read/mem_write are held until a one-cycle mem_resp
// pulse; downstream pmem_read/pmem_write are held (with stable address and
// data) until a one-cycle pmem_resp pulse. pmem_read and pmem_write are
// never both high.
module l2_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              wb_empty,
  output logic              wb_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_PREAD = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PW:0]       count_q, count_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];

  logic              mem_resp_q, mem_resp_d;
  logic [LINE_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic              ent_we;
  logic              ent_alloc;
  logic [PW-1:0]     ent_idx;
  logic              drain_done;
  logic              full;

  assign full     = (count_q == FULL_CNT);
  assign wb_full  = full;
  assign wb_empty = (count_q == '0);

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Address lookup against every valid entry; coalescing keeps matches unique.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == mem_address)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Next-state logic for the request FSM, FIFO pointers and registered outputs.
  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    ent_we         = 1'b0;
    ent_alloc      = 1'b0;
    ent_idx        = tail_q;
    drain_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          // Simultaneous read+write is treated as a write.
          if (hit) begin
            ent_we     = 1'b1;
            ent_idx    = hit_idx;
            mem_resp_d = 1'b1;
            state_d    = S_ACK;
          end else if (!full) begin
            ent_we     = 1'b1;
            ent_alloc  = 1'b1;
            ent_idx    = tail_q;
            tail_d     = tail_q + 1'b1;
            count_d    = count_q + 1'b1;
            mem_resp_d = 1'b1;
            state_d    = S_ACK;
          end else begin
            // Full: make room, then come back and accept the write.
            state_d        = S_DRAIN;
            pmem_write_d   = 1'b1;
            pmem_address_d = addr_q[head_q];
            pmem_wdata_d   = data_q[head_q];
          end
        end else if (mem_read) begin
          if (hit) begin
`ifdef WB_FORWARD_EN
            mem_rdata_d = data_q[hit_idx];
            mem_resp_d  = 1'b1;
            state_d     = S_ACK;
`else
            // Keep draining until the line is no longer buffered so the
            // pmem read sees the newest data.
            state_d        = S_DRAIN;
            pmem_write_d   = 1'b1;
            pmem_address_d = addr_q[head_q];
            pmem_wdata_d   = data_q[head_q];
`endif
          end else begin
            state_d        = S_PREAD;
            pmem_read_d    = 1'b1;
            pmem_address_d = mem_address;
          end
        end else if (count_q != '0) begin
          state_d        = S_DRAIN;
          pmem_write_d   = 1'b1;
          pmem_address_d = addr_q[head_q];
          pmem_wdata_d   = data_q[head_q];
        end
      end
      S_ACK: begin
        // L2 drops its request after resp, so nothing is sampled here.
        state_d = S_IDLE;
      end
      S_PREAD: begin
        if (pmem_resp) begin
          mem_rdata_d = pmem_rdata;
          pmem_read_d = 1'b0;
          mem_resp_d  = 1'b1;
          state_d     = S_ACK;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          pmem_write_d = 1'b0;
          drain_done   = 1'b1;
          head_d       = head_q + 1'b1;
          count_d      = count_q - 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, pointers and registered outputs; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Entry valid bits: set on allocation at tail, cleared when head drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (drain_done) valid_q[head_q] <= 1'b0;
      if (ent_alloc)  valid_q[tail_q] <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (ent_we) begin
      addr_q[ent_idx] <= mem_address;
      data_q[ent_idx] <= mem_wdata;
    end
  end

endmodule
